// File: rtl/ws2812_frame_tx.sv
// ws2812_frame_tx: streams a frame of NUM_PIXELS WS2812 pixels, MSB first, with
// no gaps between pixels, then holds the line low for the latch period.
// Pixels arrive over valid/ready into a one-entry holding buffer so the next
// pixel can be fetched while the current one is being shifted out.
// Optional build macro WS2812_BLANK_ON_UNDERRUN_EN: a missing pixel is sent as
// all-zero bits and the frame runs to full length instead of truncating.
module ws2812_frame_tx #(
  parameter int BITS_PER_PIXEL = 24,
  parameter int NUM_PIXELS     = 64,
  parameter int T0H            = 16,
  parameter int T1H            = 32,
  parameter int T0L            = 34,
  parameter int T1L            = 18,
  parameter int TRESET         = 2000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BITS_PER_PIXEL-1:0] pixel_data,
  input  logic                      pixel_valid,
  output logic                      pixel_ready,
  output logic                      datastream,
  output logic                      busy,
  output logic                      done,
  output logic                      underrun
);

  localparam int TM01 = (T0H > T1H) ? T0H : T1H;
  localparam int TM23 = (T0L > T1L) ? T0L : T1L;
  localparam int TM03 = (TM01 > TM23) ? TM01 : TM23;
  localparam int TMAX = (TM03 > TRESET) ? TM03 : TRESET;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int PW   = $clog2(NUM_PIXELS + 1);
  localparam int BW   = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;

  localparam logic [PW-1:0] NPIX     = PW'(NUM_PIXELS);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_PIXEL - 1);

  typedef enum logic [2:0] {IDLE, FETCH, HIGH, LOW, LATCH} state_t;

  state_t                    state_q, state_d;
  logic [TW-1:0]             tmr_q, tmr_d;
  logic [BITS_PER_PIXEL-1:0] shreg_q, shreg_d;
  logic [BITS_PER_PIXEL-1:0] buf_q, buf_d;
  logic                      buf_full_q, buf_full_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [PW-1:0]             acc_q, acc_d;    // pixels accepted (or blanked) this frame
  logic [PW-1:0]             sent_q, sent_d;  // pixels loaded into the shift register
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      und_q, und_d;
  logic                      ds_q, ds_d;
  logic                      hs;

  // Timer reload values are one less than the phase length: the phase ends on 0.
  function automatic logic [TW-1:0] high_len(input logic b);
    return b ? TW'(T1H - 1) : TW'(T0H - 1);
  endfunction

  function automatic logic [TW-1:0] low_len(input logic b);
    return b ? TW'(T1L - 1) : TW'(T0L - 1);
  endfunction

  assign pixel_ready = ~buf_full_q & busy_q & (acc_q < NPIX);
  assign hs          = pixel_valid & pixel_ready;
  assign datastream  = ds_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign underrun    = und_q;

  // Next-state logic: frame sequencing, bit timing and buffer management.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    shreg_d    = shreg_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    bit_d      = bit_q;
    acc_d      = acc_q;
    sent_d     = sent_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    und_d      = 1'b0;

    // Outside FETCH an accepted pixel parks in the holding buffer. Ready was
    // derived from an empty buffer, so this never collides with a drain.
    if (hs) begin
      acc_d = acc_q + 1'b1;
      if (state_q != FETCH) begin
        buf_d      = pixel_data;
        buf_full_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          busy_d  = 1'b1;
          acc_d   = '0;
          sent_d  = '0;
        end
      end

      FETCH: begin
        // First pixel bypasses the buffer straight into the shift register.
        if (hs) begin
          shreg_d = pixel_data;
          bit_d   = '0;
          sent_d  = PW'(1);
          tmr_d   = high_len(pixel_data[BITS_PER_PIXEL-1]);
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (tmr_q == '0) begin
          tmr_d   = low_len(shreg_q[BITS_PER_PIXEL-1]);
          state_d = LOW;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      LOW: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end else if (bit_q != LAST_BIT) begin
          shreg_d = shreg_q << 1;
          bit_d   = bit_q + 1'b1;
          tmr_d   = high_len(shreg_q[BITS_PER_PIXEL-2]);
          state_d = HIGH;
        end else if (sent_q < NPIX) begin
          if (buf_full_q) begin
            // Pixel boundary: reload from the buffer with no idle cycle.
            shreg_d    = buf_q;
            buf_full_d = 1'b0;
            bit_d      = '0;
            sent_d     = sent_q + 1'b1;
            tmr_d      = high_len(buf_q[BITS_PER_PIXEL-1]);
            state_d    = HIGH;
          end else begin
            und_d = 1'b1;
`ifdef WS2812_BLANK_ON_UNDERRUN_EN
            // Substitute a black pixel; it consumes a slot so the frame
            // still carries exactly NUM_PIXELS pixels.
            shreg_d = '0;
            bit_d   = '0;
            sent_d  = sent_q + 1'b1;
            acc_d   = acc_d + 1'b1;
            tmr_d   = high_len(1'b0);
            state_d = HIGH;
`else
            tmr_d   = TW'(TRESET - 1);
            state_d = LATCH;
`endif
          end
        end else begin
          tmr_d   = TW'(TRESET - 1);
          state_d = LATCH;
        end
      end

      LATCH: begin
        if (tmr_q == '0) begin
          done_d     = 1'b1;
          busy_d     = 1'b0;
          buf_full_d = 1'b0;  // drop any stray pixel pushed after the frame filled
          state_d    = IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    ds_d = (state_d == HIGH);
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      shreg_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      bit_q      <= '0;
      acc_q      <= '0;
      sent_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      und_q      <= 1'b0;
      ds_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      shreg_q    <= shreg_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      bit_q      <= bit_d;
      acc_q      <= acc_d;
      sent_q     <= sent_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      und_q      <= und_d;
      ds_q       <= ds_d;
    end
  end

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Directed bench for ws2812_frame_tx: a line decoder turns the serial output
// into bits and flags any cell whose high/low lengths are off.
module tb_ws2812_frame_tx;
  localparam int B = 24, N = 3, T0H = 2, T1H = 4, T0L = 4, T1L = 2, TRESET = 10;

  logic         clk = 1'b0;
  logic         reset, start, pixel_valid, pixel_ready, datastream, busy, done, underrun;
  logic [B-1:0] pixel_data;

  ws2812_frame_tx #(.BITS_PER_PIXEL(B), .NUM_PIXELS(N), .T0H(T0H), .T1H(T1H),
                    .T0L(T0L), .T1L(T1L), .TRESET(TRESET)) dut (
    .clk(clk), .reset(reset), .start(start), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .datastream(datastream),
    .busy(busy), .done(done), .underrun(underrun));

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;

  // ---- line decoder / event counters (sampled on negedge) ----
  logic     cells[$];
  int       bad_cnt = 0, done_cnt = 0, und_cnt = 0, busy_err = 0;
  int       hi = 0, lo = 0;
  bit       in_cell = 0;
  logic     prev_busy = 0;

  function automatic void finalize(input int h, input int l, input bit term);
    logic b;
    int   exp_lo;
    b      = (h == T1H);
    exp_lo = (b ? T1L : T0L) + (term ? TRESET : 0);
    if ((h != T1H && h != T0H) || l != exp_lo) bad_cnt++;
    cells.push_back(b);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      in_cell = 0; hi = 0; lo = 0;
    end else begin
      if (done) begin
        done_cnt++;
        if (busy !== 1'b0 || prev_busy !== 1'b1) busy_err++;
        if (in_cell) finalize(hi, lo, 1'b1);
        in_cell = 0; hi = 0; lo = 0;
      end
      if (datastream) begin
        if (in_cell && lo > 0) begin
          finalize(hi, lo, 1'b0);
          hi = 0; lo = 0;
        end
        in_cell = 1; hi++;
      end else if (in_cell) begin
        lo++;
      end
      if (underrun) und_cnt++;
    end
    prev_busy = busy;
  end

  // ---- pixel feeder: presents feed_q in order, pops on handshake ----
  logic [B-1:0] feed_q[$];
  int           hs_cnt = 0;
  bit           alt_mode = 0;
  bit           hs_prev = 0;
  int           fcyc = 0;

  initial begin
    pixel_valid = 1'b0;
    pixel_data  = '0;
    forever begin
      @(negedge clk);
      if (hs_prev) begin
        hs_cnt++;
        if (feed_q.size() > 0) void'(feed_q.pop_front());
      end
      fcyc++;
      if (feed_q.size() > 0 && !(alt_mode && fcyc[0])) begin
        pixel_valid = 1'b1;
        pixel_data  = feed_q[0];
      end else begin
        pixel_valid = 1'b0;
      end
      hs_prev = pixel_valid && pixel_ready && !reset;
    end
  end

  task automatic clear_stats();
    cells.delete();
    bad_cnt = 0; done_cnt = 0; und_cnt = 0; busy_err = 0; hs_cnt = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
    if (done_cnt == 0) begin
      n_fail++;
      $display("FAIL %s: timeout waiting for done", name);
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [3*B-1:0] cells_vec();
    logic [3*B-1:0] v = '0;
    foreach (cells[i]) v = {v[3*B-2:0], cells[i]};
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (datastream !== 1'b0) begin n_fail++; $display("FAIL reset_ds: got %b want 0", datastream); end
    n_cmp++; if (pixel_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", pixel_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_pixel();
    logic [3*B-1:0] exp_v;
    int             exp_n, exp_u;
    clear_stats();
    feed_q.push_back(24'h800001);
    repeat (2) @(posedge clk);
    #1;
    pulse_start();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_done("single");
`ifdef WS2812_BLANK_ON_UNDERRUN_EN
    exp_n = 72; exp_u = 2; exp_v = {24'h800001, 24'h000000, 24'h000000};
`else
    exp_n = 24; exp_u = 1; exp_v = {48'h0, 24'h800001};
`endif
    n_cmp++; if (cells.size() != exp_n) begin n_fail++; $display("FAIL single_cells: got %0d want %0d", cells.size(), exp_n); end
    n_cmp++; if (cells_vec() !== exp_v) begin n_fail++; $display("FAIL single_bits: got %h want %h", cells_vec(), exp_v); end
    n_cmp++; if (bad_cnt != 0) begin n_fail++; $display("FAIL single_timing: got %0d bad cells want 0", bad_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL single_done: got %0d want 1", done_cnt); end
    n_cmp++; if (busy_err != 0) begin n_fail++; $display("FAIL single_busy_fall: got %0d errors want 0", busy_err); end
    n_cmp++; if (und_cnt != exp_u) begin n_fail++; $display("FAIL single_underrun: got %0d want %0d", und_cnt, exp_u); end
  endtask

  task automatic run_three(input string name, input logic [B-1:0] a, input logic [B-1:0] b2,
                           input logic [B-1:0] c, input bit alt);
    logic [3*B-1:0] exp_v;
    clear_stats();
    alt_mode = alt;
    feed_q.push_back(a); feed_q.push_back(b2); feed_q.push_back(c);
    exp_v = {a, b2, c};
    pulse_start();
    wait_done(name);
    alt_mode = 0;
    n_cmp++; if (cells.size() != 72) begin n_fail++; $display("FAIL %s_cells: got %0d want 72", name, cells.size()); end
    n_cmp++; if (cells_vec() !== exp_v) begin n_fail++; $display("FAIL %s_bits: got %h want %h", name, cells_vec(), exp_v); end
    n_cmp++; if (bad_cnt != 0) begin n_fail++; $display("FAIL %s_timing: got %0d bad cells want 0", name, bad_cnt); end
    n_cmp++; if (hs_cnt != 3) begin n_fail++; $display("FAIL %s_handshakes: got %0d want 3", name, hs_cnt); end
    n_cmp++; if (und_cnt != 0) begin n_fail++; $display("FAIL %s_underrun: got %0d want 0", name, und_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done: got %0d want 1", name, done_cnt); end
  endtask

  task automatic test_three_pixels();
    run_three("three", 24'hFFFFFF, 24'h000000, 24'hA5A5A5, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_three("b2b", 24'h123456, 24'h654321, 24'h0F0F0F, 1'b1);
  endtask

  task automatic test_underrun();
    logic [3*B-1:0] exp_v;
    int             exp_n;
    clear_stats();
    feed_q.push_back(24'hC30FF1);
    pulse_start();
    for (int i = 0; i < 400 && und_cnt == 0; i++) @(negedge clk);
    n_cmp++; if (und_cnt != 1) begin n_fail++; $display("FAIL und_pulse: got %0d want 1", und_cnt); end
    n_cmp++; if (cells.size() != 23) begin n_fail++; $display("FAIL und_position: got %0d cells want 23", cells.size()); end
`ifdef WS2812_BLANK_ON_UNDERRUN_EN
    feed_q.push_back(24'h3C3C3C);
    exp_n = 72; exp_v = {24'hC30FF1, 24'h000000, 24'h3C3C3C};
`else
    exp_n = 24; exp_v = {48'h0, 24'hC30FF1};
`endif
    wait_done("underrun");
    n_cmp++; if (cells.size() != exp_n) begin n_fail++; $display("FAIL und_cells: got %0d want %0d", cells.size(), exp_n); end
    n_cmp++; if (cells_vec() !== exp_v) begin n_fail++; $display("FAIL und_bits: got %h want %h", cells_vec(), exp_v); end
    n_cmp++; if (bad_cnt != 0) begin n_fail++; $display("FAIL und_timing: got %0d bad cells want 0", bad_cnt); end
    n_cmp++; if (und_cnt != 1) begin n_fail++; $display("FAIL und_total: got %0d want 1", und_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int highs;
    clear_stats();
    feed_q.push_back(24'hFFFFFF); feed_q.push_back(24'h0000FF); feed_q.push_back(24'h00FF00);
    pulse_start();
    // advance into the third bit cell, two cycles into its HIGH
    highs = 0;
    for (int i = 0; i < 200 && highs < 10; i++) begin
      @(negedge clk);
      if (datastream) highs++;
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (datastream !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ds: got %b want 0", datastream); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    feed_q.delete();
    reset = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++; if (done_cnt != 0) begin n_fail++; $display("FAIL rst_mid_nodone: got %0d want 0", done_cnt); end
    @(posedge clk); #1;
    run_three("rst_rerun", 24'h00FF00, 24'h5A5A5A, 24'h800001, 1'b0);
  endtask

  task automatic test_start_ignored();
    clear_stats();
    feed_q.push_back(24'hF0F0F0); feed_q.push_back(24'h0F0F0F); feed_q.push_back(24'hAAAAAB);
    pulse_start();
    for (int i = 0; i < 100 && !datastream; i++) @(negedge clk);
    pulse_start();  // during HIGH
    for (int i = 0; i < 1000 && cells.size() < 71; i++) @(negedge clk);
    for (int i = 0; i < 20 && datastream; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    pulse_start();  // during LATCH
    wait_done("start_ign");
    repeat (30) @(negedge clk);
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL start_ign_done: got %0d want 1", done_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_ign_busy: got %b want 0", busy); end
    n_cmp++; if (cells_vec() !== {24'hF0F0F0, 24'h0F0F0F, 24'hAAAAAB}) begin
      n_fail++; $display("FAIL start_ign_bits: got %h want %h", cells_vec(), {24'hF0F0F0, 24'h0F0F0F, 24'hAAAAAB});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    test_reset();
    test_single_pixel();
    test_three_pixels();
    test_back_to_back();
    test_underrun();
    test_reset_mid_frame();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
